// File: rtl/p2_read_scheduler.sv
// Read scheduler: streams the pooling-2 output map (NUM_CH channels of 4x4 words) to the
// fully-connected layer through a 2-entry FIFO with ready/valid backpressure.
module p2_read_scheduler #(
    parameter int unsigned NUM_CH = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [3:0]        mem_ch,
    output logic [3:0]        mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] LastCh  = 4'(NUM_CH - 1);
    localparam logic [7:0] LastIdx = 8'(NUM_CH * 16 - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        ch_q, addr_q;
    logic              inflight_q;
    logic [7:0]        inflight_idx_q;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [7:0]        fifo_idx_q  [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;

    logic in_pass, flush, push, pop, rd_ok, last_rd;

    assign in_pass = (state_q == StRead) || (state_q == StDrain);
    assign flush   = in_pass && abort;
    assign push    = reset && inflight_q && !flush;
    assign pop     = out_valid && out_ready;
    assign last_rd = (ch_q == LastCh) && (addr_q == 4'hf);
    // Buffered + in-flight words, less the one leaving now, must leave room in the FIFO.
    assign rd_ok   = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start && !abort) state_d = StRead;
            StRead: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (mem_rd_en && last_rd) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (pop && out_last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Every output is gated by reset so nothing leaks while reset is held low.
    always_comb begin
        mem_rd_en = reset && (state_q == StRead) && !abort && rd_ok;
        mem_ch    = mem_rd_en ? ch_q : 4'd0;
        mem_addr  = mem_rd_en ? addr_q : 4'd0;
        out_valid = reset && (count_q != 2'd0);
        out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
        out_idx   = out_valid ? fifo_idx_q[rd_ptr_q] : 8'd0;
        out_last  = out_valid && (out_idx == LastIdx);
        busy      = reset && in_pass;
        done      = reset && (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            ch_q           <= 4'd0;
            addr_q         <= 4'd0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= 8'd0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
        end else begin
            inflight_q <= mem_rd_en;
            if (mem_rd_en) begin
                inflight_idx_q <= {ch_q, addr_q};
                addr_q         <= addr_q + 4'd1;
                if (addr_q == 4'hf) begin
                    ch_q <= last_rd ? 4'd0 : ch_q + 4'd1;
                end
            end
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_rdata;
            fifo_idx_q[wr_ptr_q]  <= inflight_idx_q;
        end
    end

endmodule

// File: tb/tb_p2_read_scheduler.sv
// Bench for p2_read_scheduler: random memory contents and ready patterns, with the expected
// stream derived from the flat index order ch*16+addr and a 1-cycle memory model.
module tb_p2_read_scheduler;

    localparam int NCH = 12;
    localparam int DW  = 16;
    localparam int NW  = NCH * 16;

    logic          clk = 1'b0;
    logic          reset, start, abort, out_ready;
    logic          mem_rd_en, out_valid, out_last, busy, done;
    logic [3:0]    mem_ch, mem_addr;
    logic [DW-1:0] mem_rdata, out_data;
    logic [7:0]    out_idx;

    p2_read_scheduler #(.NUM_CH(NCH), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .mem_rd_en(mem_rd_en), .mem_ch(mem_ch), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory model: data for the read issued in a cycle appears in the following cycle.
    logic [DW-1:0] mem [256];
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem[{mem_ch, mem_addr}] : DW'($urandom);

    int n_vec = 0, n_err = 0, cyc = 0;
    int rd_q[$], rd_t[$], oi_q[$], ot_q[$], done_t[$], occ_q[$];
    logic [DW-1:0] od_q[$];
    logic          ol_q[$];
    logic [DW+9:0] hp_q[$], hc_q[$], prev_b, cur_b;
    logic          prev_stall;
    logic [DW+20:0] s_all;
    logic          s_busy, s_valid, s_rd_en;

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    endtask

    task automatic clear_log();
        rd_q.delete(); rd_t.delete(); oi_q.delete(); ot_q.delete(); od_q.delete();
        ol_q.delete(); done_t.delete(); occ_q.delete(); hp_q.delete(); hc_q.delete();
        prev_stall = 1'b0;
    endtask

    // Drive one cycle of inputs, record what the DUT shows mid-cycle, advance past the edge.
    task automatic cycle(input logic st, input logic ab, input logic rdy);
        start = st; abort = ab; out_ready = rdy;
        #2;
        s_all   = {mem_rd_en, mem_ch, mem_addr, out_data, out_idx, out_valid, out_last, busy,
                   done};
        s_busy  = busy; s_valid = out_valid; s_rd_en = mem_rd_en;
        cur_b   = {out_valid, out_last, out_idx, out_data};
        if (mem_rd_en) begin
            occ_q.push_back(rd_q.size() - oi_q.size() - ((out_valid && out_ready) ? 1 : 0));
            rd_q.push_back(int'({mem_ch, mem_addr}));
            rd_t.push_back(cyc);
        end
        if (prev_stall) begin
            hp_q.push_back(prev_b);
            hc_q.push_back(cur_b);
        end
        if (out_valid && out_ready) begin
            oi_q.push_back(int'(out_idx)); od_q.push_back(out_data);
            ol_q.push_back(out_last); ot_q.push_back(cyc);
        end
        if (done) done_t.push_back(cyc);
        prev_b = cur_b;
        prev_stall = out_valid && !out_ready;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'($urandom), 1'b1);
            n_vec++;
            if (s_all !== '0) begin
                n_err++; $display("FAIL reset_outputs: got %h want 0", s_all);
            end
        end
        reset = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (s_all !== '0 || done_t.size() != 0) begin
            n_err++; $display("FAIL idle_after_reset: got %h want 0", s_all);
        end
    endtask

    task automatic test_full_pass();
        int t0;
        fill_mem(); clear_log();
        t0 = cyc;
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 260 && done_t.size() == 0; i++) cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (oi_q.size() != NW || rd_q.size() != NW) begin
            n_err++; $display("FAIL full_count: got %0d words %0d reads want %0d", oi_q.size(),
                              rd_q.size(), NW);
        end else begin
            for (int k = 0; k < NW; k++) begin
                n_vec++;
                if (rd_q[k] != k || oi_q[k] != k || od_q[k] !== mem[k] || ol_q[k] !== (k == NW-1))
                begin
                    n_err++; $display("FAIL full_word: k=%0d got rd=%0d idx=%0d data=%h last=%b",
                                      k, rd_q[k], oi_q[k], od_q[k], ol_q[k]); break;
                end
            end
            n_vec++;
            if (rd_t[0] != t0 + 1 || ot_q[0] != t0 + 3 || ot_q[NW-1] != t0 + 194) begin
                n_err++; $display("FAIL full_latency: got rd %0d first %0d last %0d want 1 3 194",
                                  rd_t[0] - t0, ot_q[0] - t0, ot_q[NW-1] - t0);
            end
        end
        n_vec++;
        if (done_t.size() != 1 || done_t[0] != t0 + 195) begin
            n_err++; $display("FAIL full_done: got %0d pulses first at %0d want 1 at 195",
                              done_t.size(), (done_t.size() > 0) ? done_t[0] - t0 : -1);
        end
    endtask

    task automatic test_ready_toggle();
        int i;
        fill_mem(); clear_log();
        cycle(1'b1, 1'b0, 1'b1);
        for (i = 1; i < 1200 && done_t.size() == 0; i++) cycle(1'b0, 1'b0, (i % 4 == 0) || (i % 4 == 3));
        n_vec++;
        if (oi_q.size() != NW || done_t.size() != 1) begin
            n_err++; $display("FAIL toggle_count: got %0d words %0d done want %0d 1", oi_q.size(),
                              done_t.size(), NW);
        end else begin
            for (int k = 0; k < NW; k++) begin
                n_vec++;
                if (rd_q[k] != k || oi_q[k] != k || od_q[k] !== mem[k]) begin
                    n_err++; $display("FAIL toggle_word: k=%0d got idx=%0d data=%h want %h",
                                      k, oi_q[k], od_q[k], mem[k]); break;
                end
            end
        end
        for (int k = 0; k < hp_q.size(); k++) begin
            n_vec++;
            if (hc_q[k] !== hp_q[k]) begin
                n_err++; $display("FAIL toggle_hold: got %h want %h", hc_q[k], hp_q[k]); break;
            end
        end
        for (int k = 0; k < occ_q.size(); k++) begin
            n_vec++;
            if (occ_q[k] >= 2) begin
                n_err++; $display("FAIL toggle_occupancy: got %0d want <2", occ_q[k]); break;
            end
        end
    endtask

    task automatic test_stall();
        int s0 = -1, left = 0, late_rd = 0;
        logic rdy;
        fill_mem(); clear_log();
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 400 && done_t.size() == 0; i++) begin
            if (left > 0) begin
                rdy = 1'b0; left--;
            end else if (s0 < 0 && out_valid && out_idx == 8'd15) begin
                s0 = cyc; left = 19; rdy = 1'b0;
            end else begin
                rdy = 1'b1;
            end
            cycle(1'b0, 1'b0, rdy);
        end
        foreach (rd_t[k]) if (s0 >= 0 && rd_t[k] >= s0 + 2 && rd_t[k] < s0 + 20) late_rd++;
        n_vec++;
        if (s0 < 0 || late_rd != 0) begin
            n_err++; $display("FAIL stall_reads: got %0d reads late in stall (start %0d) want 0",
                              late_rd, s0);
        end
        n_vec++;
        if (oi_q.size() != NW || done_t.size() != 1) begin
            n_err++; $display("FAIL stall_count: got %0d words want %0d", oi_q.size(), NW);
        end else begin
            n_vec++;
            if (ot_q[15] != s0 + 20 || oi_q[15] != 15 || od_q[15] !== mem[15]) begin
                n_err++; $display("FAIL stall_resume: got idx %0d at %0d want 15 at %0d",
                                  oi_q[15], ot_q[15], s0 + 20);
            end
            for (int k = 0; k < NW; k++) begin
                n_vec++;
                if (oi_q[k] != k || od_q[k] !== mem[k]) begin
                    n_err++; $display("FAIL stall_word: k=%0d got idx=%0d data=%h want %h",
                                      k, oi_q[k], od_q[k], mem[k]); break;
                end
            end
        end
    endtask

    task automatic test_abort();
        fill_mem(); clear_log();
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 200 && !(out_valid && out_idx == 8'd100); i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (s_busy !== 1'b0 || s_valid !== 1'b0 || s_rd_en !== 1'b0) begin
            n_err++; $display("FAIL abort_idle: got busy=%b valid=%b rd=%b want 0 0 0", s_busy,
                              s_valid, s_rd_en);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (done_t.size() != 0 || oi_q.size() != 101) begin
            n_err++; $display("FAIL abort_nodone: got %0d done %0d words want 0 101",
                              done_t.size(), oi_q.size());
        end
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (s_busy !== 1'b0) begin
            n_err++; $display("FAIL abort_priority: got busy=%b want 0", s_busy);
        end
        fill_mem(); clear_log();
        cycle(1'b1, 1'b0, 1'($urandom));
        for (int i = 0; i < 1500 && done_t.size() == 0; i++)
            cycle(1'b0, 1'b0, $urandom_range(0, 3) != 0);
        n_vec++;
        if (oi_q.size() != NW || done_t.size() != 1) begin
            n_err++; $display("FAIL restart_count: got %0d words want %0d", oi_q.size(), NW);
        end else begin
            for (int k = 0; k < NW; k++) begin
                n_vec++;
                if (oi_q[k] != k || od_q[k] !== mem[k] || ol_q[k] !== (k == NW-1)) begin
                    n_err++; $display("FAIL restart_word: k=%0d got idx=%0d data=%h want %h",
                                      k, oi_q[k], od_q[k], mem[k]); break;
                end
            end
        end
        foreach (hp_q[k]) begin
            n_vec++;
            if (hc_q[k] !== hp_q[k]) begin
                n_err++; $display("FAIL restart_hold: got %h want %h", hc_q[k], hp_q[k]); break;
            end
        end
        foreach (occ_q[k]) begin
            n_vec++;
            if (occ_q[k] >= 2) begin
                n_err++; $display("FAIL restart_occupancy: got %0d want <2", occ_q[k]); break;
            end
        end
    endtask

    task automatic test_start_ignored_and_reset_drain();
        int words;
        fill_mem(); clear_log();
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 300 && done_t.size() == 0; i++) cycle(1'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (oi_q.size() != NW || rd_q.size() != NW || done_t.size() != 1) begin
            n_err++; $display("FAIL start_ignored: got %0d words %0d reads %0d done want %0d",
                              oi_q.size(), rd_q.size(), done_t.size(), NW);
        end
        fill_mem(); clear_log();
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 1000 && rd_q.size() < NW; i++) cycle(1'b0, 1'b0, 1'($urandom));
        cycle(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (s_busy !== 1'b1 || rd_q.size() != NW) begin
            n_err++; $display("FAIL drain_reached: got busy=%b reads=%0d want 1 %0d", s_busy,
                              rd_q.size(), NW);
        end
        words = oi_q.size();
        reset = 1'b0;
        cycle(1'b1, 1'b0, 1'b1);
        n_vec++;
        if (s_all !== '0) begin
            n_err++; $display("FAIL drain_reset_during: got %h want 0", s_all);
        end
        reset = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (s_all !== '0) begin
            n_err++; $display("FAIL drain_reset_after: got %h want 0", s_all);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (rd_q.size() != NW || oi_q.size() != words || done_t.size() != 0) begin
            n_err++; $display("FAIL drain_reset_quiet: got %0d reads %0d words %0d done",
                              rd_q.size(), oi_q.size() - words, done_t.size());
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        prev_stall = 1'b0; prev_b = '0;
        @(posedge clk); #1;
        test_reset();
        test_full_pass();
        test_ready_toggle();
        test_stall();
        test_abort();
        test_start_ignored_and_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
